// File: rtl/rr_arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package rr_arb_pkg;
   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;
endpackage

// File: rtl/onehot_dec_3x8.sv
// Combinational 3-to-8 one-hot decoder; zero latency, no flow control.
module onehot_dec_3x8
   import rr_arb_pkg::*;
(
   input  logic [IDX_W-1:0]   i_idx,
   output logic [NUM_REQ-1:0] o_onehot
);
   always_comb begin
      o_onehot        = '0;
      o_onehot[i_idx] = 1'b1;
   end
endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter, grant one cycle after a request is seen in IDLE, held until released.
// Optional per-ownership hold limit (MAX_HOLD cycles) compiled in with RR_ARB_TIMEOUT_EN.
module rr_arbiter_8
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid
);
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("rr_arbiter_8: MAX_HOLD must be within 1..255");
   end

   // First requester at or after the pointer, wrapping modulo 8.
   function automatic logic [IDX_W-1:0] f_rr_scan(input logic [NUM_REQ-1:0] i_vec,
                                                  input logic [IDX_W-1:0]   i_ptr);
      logic [IDX_W-1:0] v_idx;
      logic             v_found;
      v_found   = 1'b0;
      f_rr_scan = i_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_idx = i_ptr + IDX_W'(k);
         if (!v_found && i_vec[v_idx]) begin
            f_rr_scan = v_idx;
            v_found   = 1'b1;
         end
      end
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [IDX_W-1:0]   r_gnt_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] w_dec;
   logic [NUM_REQ-1:0] w_gnt_nxt;
   logic               w_timeout;

`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] r_hold;

   // Counter is zero on the first GRANT cycle, so the grant lasts exactly MAX_HOLD cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold <= 8'd0;
      end else if (r_state == ST_GRANT) begin
         r_hold <= r_hold + 8'd1;
      end else begin
         r_hold <= 8'd0;
      end
   end

   assign w_timeout = (r_hold == 8'(MAX_HOLD - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_gnt_idx;
      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               w_state_nxt = ST_GRANT;
               w_idx_nxt   = f_rr_scan(req, r_ptr);
            end
         end
         ST_GRANT: begin
            if (!req[r_gnt_idx] || w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = r_gnt_idx + 3'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   onehot_dec_3x8 u_dec (
      .i_idx    (w_idx_nxt),
      .o_onehot (w_dec)
   );

   assign w_gnt_nxt = (w_state_nxt == ST_GRANT) ? w_dec : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_gnt_idx <= '0;
         r_gnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_gnt_idx <= w_idx_nxt;
         r_gnt     <= w_gnt_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = r_gnt_idx;
   assign gnt_valid = (r_state == ST_GRANT);
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed scenarios plus randomized traffic, checked against an ownership-level reference model.
module tb_rr_arbiter_8;
`ifdef RR_ARB_TIMEOUT_EN
   localparam int TB_MAX_HOLD = 4;
   localparam bit TB_TIMEOUT  = 1'b1;
`else
   localparam int TB_MAX_HOLD = 16;
   localparam bit TB_TIMEOUT  = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: current owner (-1 = nobody), rotation start, cycles owned so far.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_hold  = 0;

   rr_arbiter_8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 8; k++) begin
            if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
         end
         m_hold = 1;
      end else if (!req[m_owner] || (TB_TIMEOUT && m_hold >= TB_MAX_HOLD)) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = -1;
      end else begin
         m_hold++;
      end
   end

   always @(negedge clk) begin
      logic [7:0] exp_gnt;
      exp_gnt = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
      check_eq("model_gnt", gnt, exp_gnt);
      check_eq("model_vld", gnt_valid, m_owner >= 0);
      if (m_owner >= 0) check_eq("model_idx", gnt_idx, m_owner);
   end

   initial begin
      int order[$];
      int idle_run;
      int held;
      int guard;

      // Reset with everyone requesting
      rst = 1'b1;
      req = 8'hFF;
      repeat (2) begin
         @(negedge clk);
         check_eq("rst_gnt", gnt, 8'h00);
         check_eq("rst_vld", gnt_valid, 1'b0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      step(1);
      check_eq("first_gnt", gnt, 8'h01);
      check_eq("first_idx", gnt_idx, 3'd0);

      // Single requester
      req = 8'h00;
      step(1);
      check_eq("rel0_gnt", gnt, 8'h00);
      req = 8'h10;
      step(1);
      check_eq("single_gnt", gnt, 8'h10);
      check_eq("single_idx", gnt_idx, 3'd4);
      req = 8'h00;
      step(1);
      check_eq("single_rel", gnt, 8'h00);
      check_eq("single_vld", gnt_valid, 1'b0);

      // Fairness: everyone requests, owners drop after 3 cycles and re-raise in IDLE
      rst = 1'b1;
      req = 8'h00;
      step(1);
      rst = 1'b0;
      req = 8'hFF;
      idle_run = 0;
      held = 0;
      guard = 0;
      while (order.size() < 9 && guard < 300) begin
         step(1);
         guard++;
         if (gnt_valid) begin
            if (held == 0) begin
               if (order.size() > 0) check_eq("fair_gap", idle_run, 1);
               order.push_back(int'(gnt_idx));
               idle_run = 0;
            end
            held++;
            if (held == 3) req[gnt_idx] = 1'b0;
         end else begin
            idle_run++;
            held = 0;
            req = 8'hFF;
         end
      end
      check_eq("fair_count", order.size(), 9);
      foreach (order[i]) check_eq("fair_order", order[i], i % 8);

      // Wrap: 7 then 0 and 7 together
      req = 8'h00;
      step(1);
      check_eq("wrap_idle0", gnt, 8'h00);
      req = 8'h80;
      step(1);
      check_eq("wrap_g7", gnt, 8'h80);
      req = 8'h00;
      step(1);
      check_eq("wrap_idle1", gnt, 8'h00);
      req = 8'h81;
      step(1);
      check_eq("wrap_g0", gnt, 8'h01);
      req = 8'h80;
      step(1);
      check_eq("wrap_idle2", gnt, 8'h00);
      step(1);
      check_eq("wrap_g7b", gnt, 8'h80);
      req = 8'h00;
      step(1);

`ifdef RR_ARB_TIMEOUT_EN
      begin
         logic [7:0] exp_seq [11];
         exp_seq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                     8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h01};
         req = 8'h05;
         for (int i = 0; i < 11; i++) begin
            step(1);
            check_eq("timeout_seq", gnt, exp_seq[i]);
         end
      end
`else
      req = 8'h05;
      step(1);
      for (int i = 0; i < 100; i++) begin
         check_eq("hold_forever", gnt, 8'h01);
         step(1);
      end
`endif
      req = 8'h00;
      step(1);

      // Reset mid-grant
      req = 8'h04;
      step(1);
      check_eq("mid_gnt", gnt, 8'h04);
      rst = 1'b1;
      req = 8'h05;
      step(1);
      check_eq("mid_rst_gnt", gnt, 8'h00);
      check_eq("mid_rst_idx", gnt_idx, 3'd0);
      check_eq("mid_rst_vld", gnt_valid, 1'b0);
      rst = 1'b0;
      step(1);
      check_eq("mid_regrant", gnt, 8'h01);

      // Random traffic; owner usually keeps its request, occasional reset
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 79) == 0);
         req = 8'($urandom);
         if ($urandom_range(0, 2) == 0) req = req & 8'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 4) != 0) req[m_owner] = 1'b1;
         step(1);
      end
      rst = 1'b0;
      req = 8'h00;
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
